// File: rtl/mvp_pkg.sv
// rtl/mvp_pkg.sv - shared state type, default sizes and lane-width helper for mvp_acc
package mvp_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    localparam int N_DEFAULT    = 64;
    localparam int AW_DEFAULT   = 32;
    localparam int MAXP_DEFAULT = 16;

    // A lane sum of N single-bit products needs clog2(N) magnitude bits plus sign and carry.
    function automatic int lane_in_width(input int n);
        return $clog2(n) + 2;
    endfunction

endpackage

// File: rtl/mvp_acc_lane.sv
// rtl/mvp_acc_lane.sv - one lane: sign-extend, negate, shift-add, acc register; clamp when MVP_ACC_SAT_EN
module mvp_acc_lane #(
    parameter int IW = 8,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [IW-1:0] x,
    input  logic          neg,
    input  logic          load,
    input  logic          clear,
    output logic [AW-1:0] acc_next
);

    logic [AW-1:0] acc;

`ifdef MVP_ACC_SAT_EN
    localparam int WW = AW + 2;
    localparam logic signed [WW-1:0] HI = {3'b000, {(AW-1){1'b1}}};
    localparam logic signed [WW-1:0] LO = {3'b111, {(AW-1){1'b0}}};

    logic signed [WW-1:0] xw;
    logic signed [WW-1:0] sw;
    logic signed [WW-1:0] acc_w;
    logic signed [WW-1:0] sum_w;

    // Two guard bits keep the doubled accumulator plus one lane sum free of overflow before clamping.
    always_comb begin
        xw    = {{(WW-IW){x[IW-1]}}, x};
        sw    = neg ? -xw : xw;
        acc_w = {{2{acc[AW-1]}}, acc};
        sum_w = (acc_w <<< 1) + sw;
        if (sum_w > HI) begin
            acc_next = HI[AW-1:0];
        end else if (sum_w < LO) begin
            acc_next = LO[AW-1:0];
        end else begin
            acc_next = sum_w[AW-1:0];
        end
    end
`else
    logic [AW-1:0] xs;
    logic [AW-1:0] s;

    // acc is zero whenever no plane is held, so the EMPTY case needs no separate path.
    always_comb begin
        xs       = {{(AW-IW){x[IW-1]}}, x};
        s        = neg ? -xs : xs;
        acc_next = {acc[AW-2:0], 1'b0} + s;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (load) begin
            acc <= clear ? '0 : acc_next;
        end
    end

endmodule

// File: rtl/mvp_acc.sv
// rtl/mvp_acc.sv - bit-serial plane accumulator with registered valid/ready output; MVP_ACC_SAT_EN selects clamping
module mvp_acc
    import mvp_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int MAXP = MAXP_DEFAULT,
    localparam int IW  = lane_in_width(N),
    localparam int PW  = $clog2(MAXP + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N*IW-1:0] in_sum,
    input  logic            in_valid,
    input  logic            in_neg,
    input  logic            in_last,
    output logic            in_ready,
    output logic [N*AW-1:0] out_sum,
    output logic [PW-1:0]   out_planes,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [PW-1:0] MAXP_C = PW'(MAXP);

    acc_state_t      state;
    logic [PW-1:0]   cnt;
    logic [PW-1:0]   cnt_inc;
    logic [N*AW-1:0] nxt;
    logic            fire;

    // Every beat, not just the last, waits for room in the output register.
    assign in_ready = ~out_valid | out_ready;
    assign fire     = in_valid & in_ready;

    always_comb begin
        cnt_inc = PW'(1);
        if (state == ACCUM) begin
            cnt_inc = (cnt >= MAXP_C) ? MAXP_C : cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        mvp_acc_lane #(
            .IW(IW),
            .AW(AW)
        ) u_lane (
            .clk     (clk),
            .rstn    (rstn),
            .x       (in_sum[i*IW +: IW]),
            .neg     (in_neg),
            .load    (fire),
            .clear   (in_last),
            .acc_next(nxt[i*AW +: AW])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= EMPTY;
            cnt        <= '0;
            out_sum    <= '0;
            out_planes <= '0;
            out_valid  <= 1'b0;
        end else if (fire) begin
            if (in_last) begin
                out_sum    <= nxt;
                out_planes <= cnt_inc;
                out_valid  <= 1'b1;
                cnt        <= '0;
                state      <= EMPTY;
            end else begin
                cnt   <= cnt_inc;
                state <= ACCUM;
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mvp_acc.sv
// tb/tb_mvp_acc.sv - scoreboard bench for mvp_acc against a plane-list reference model
module tb_mvp_acc;

    localparam int N    = 32;
    localparam int AW   = 8;
    localparam int MAXP = 5;
    localparam int IW   = $clog2(N) + 2;
    localparam int PW   = $clog2(MAXP + 1);

    logic            clk       = 1'b0;
    logic            rstn      = 1'b0;
    logic [N*IW-1:0] in_sum    = '0;
    logic            in_valid  = 1'b0;
    logic            in_neg    = 1'b0;
    logic            in_last   = 1'b0;
    logic            in_ready;
    logic [N*AW-1:0] out_sum;
    logic [PW-1:0]   out_planes;
    logic            out_valid;
    logic            out_ready = 1'b1;

    mvp_acc #(.N(N), .AW(AW), .MAXP(MAXP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_sum    (in_sum),
        .in_valid  (in_valid),
        .in_neg    (in_neg),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_planes(out_planes),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*AW-1:0] sum;
        logic [PW-1:0]   planes;
    } exp_t;

    exp_t            exp_q[$];
    logic [N*IW-1:0] plane_x[$];
    bit              plane_neg[$];
    int              n_chk        = 0;
    int              n_fail       = 0;
    int              cyc          = 0;
    int              last_acc_cyc = -10;
    bit              rand_mode    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chkv(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Result of a whole plane sequence: weighted sum of planes, then wrap or per-plane clamp.
    function automatic logic [N*AW-1:0] model_result();
        logic [N*AW-1:0]      r;
        logic signed [IW-1:0] xl;
        longint               acc;
        longint               s;
        int                   p;
`ifdef MVP_ACC_SAT_EN
        longint hi;
        longint lo;
        hi = (longint'(1) << (AW - 1)) - 1;
        lo = -(longint'(1) << (AW - 1));
`endif
        r = '0;
        p = plane_x.size();
        for (int l = 0; l < N; l++) begin
            acc = 0;
            for (int k = 0; k < p; k++) begin
                xl = plane_x[k][l*IW +: IW];
                s  = plane_neg[k] ? -longint'(xl) : longint'(xl);
`ifdef MVP_ACC_SAT_EN
                acc = 2 * acc + s;
                if (acc > hi) acc = hi;
                else if (acc < lo) acc = lo;
`else
                acc = acc + s * (longint'(1) << (p - 1 - k));
`endif
            end
            r[l*AW +: AW] = acc[AW-1:0];
        end
        return r;
    endfunction

    task automatic record(input logic [N*IW-1:0] x, input bit neg, input bit last);
        exp_t e;
        int   p;
        plane_x.push_back(x);
        plane_neg.push_back(neg);
        if (last) begin
            p        = plane_x.size();
            e.sum    = model_result();
            e.planes = PW'(p > MAXP ? MAXP : p);
            exp_q.push_back(e);
            plane_x.delete();
            plane_neg.delete();
            last_acc_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic beat(input logic [N*IW-1:0] x, input bit neg, input bit last);
        int w;
        w        = 0;
        in_sum   = x;
        in_neg   = neg;
        in_last  = last;
        in_valid = 1'b1;
        #1;
        while (!in_ready && w < 100) begin
            tick();
            #1;
            w++;
        end
        chk("beat_accept", in_ready, 1);
        if (in_ready) record(x, neg, last);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [N*IW-1:0] rand_x();
        logic [N*IW-1:0] v;
        for (int l = 0; l < N; l++) v[l*IW +: IW] = IW'($urandom);
        return v;
    endfunction

    function automatic logic [N*IW-1:0] splat(input int val);
        logic [N*IW-1:0] v;
        for (int l = 0; l < N; l++) v[l*IW +: IW] = IW'(val);
        return v;
    endfunction

    // Monitor: checks the held output against the scoreboard head every cycle, pops on transfer.
    always @(negedge clk) begin
        #2;
        if (rstn) begin
            chk("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
            if (cyc == last_acc_cyc + 1) chk("latency_out_valid", out_valid, 1);
            if (out_valid) begin
                chk("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chkv("out_sum", out_sum, exp_q[0].sum);
                    chk("out_planes", out_planes, exp_q[0].planes);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*IW-1:0] v;
        int              len;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_planes", out_planes, 0);
        chkv("rst_out_sum", out_sum, '0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Single plane, lane0 = +5
        out_ready = 1'b0;
        v = '0;
        v[IW-1:0] = IW'(5);
        beat(v, 1'b0, 1'b1);
        #1;
        chk("single_lane0", $signed(out_sum[AW-1:0]), 5);
        chk("single_planes", out_planes, 1);
        tick();
        out_ready = 1'b1;
        idle(2);

        // Weight -3 as planes 1,0,1 with the MSB plane negated, x = +7
        out_ready = 1'b0;
        beat(splat(7), 1'b1, 1'b0);
        beat(splat(0), 1'b0, 1'b0);
        beat(splat(7), 1'b0, 1'b1);
        #1;
        chk("neg3_lane0", $signed(out_sum[AW-1:0]), -21);
        chk("neg3_lane_last", $signed(out_sum[(N-1)*AW +: AW]), -21);
        chk("neg3_planes", out_planes, 3);
        tick();

        // Backpressure: held result blocks a non-last beat until out_ready rises
        v        = rand_x();
        in_sum   = v;
        in_neg   = 1'b0;
        in_last  = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("bp_in_ready_low", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", in_ready, 1);
        record(v, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        beat(rand_x(), 1'b1, 1'b1);
        idle(2);

        // Held result drains in the same cycle a new last beat is accepted
        out_ready = 1'b0;
        beat(rand_x(), 1'b0, 1'b1);
        idle(2);
        out_ready = 1'b1;
        beat(rand_x(), 1'b1, 1'b1);
        #1;
        chk("simul_out_valid", out_valid, 1);
        tick();
        idle(2);

        // Reset mid-sequence discards the partial accumulation
        beat(rand_x(), 1'b0, 1'b0);
        beat(rand_x(), 1'b1, 1'b0);
        rstn = 1'b0;
        plane_x.delete();
        plane_neg.delete();
        exp_q.delete();
        tick();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        tick();
        rstn      = 1'b1;
        out_ready = 1'b0;
        tick();
        beat(splat(3), 1'b0, 1'b1);
        #1;
        chk("midrst_lane0", $signed(out_sum[AW-1:0]), 3);
        chk("midrst_planes", out_planes, 1);
        tick();
        out_ready = 1'b1;
        idle(2);

        // Eight planes of +62 overflow AW=8 and exceed the plane-count limit
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) beat(splat(62), 1'b0, k == 7);
        #1;
`ifdef MVP_ACC_SAT_EN
        chk("p62_lane0", $signed(out_sum[AW-1:0]), 127);
`else
        chk("p62_lane0", $signed(out_sum[AW-1:0]), -62);
`endif
        chk("p62_planes", out_planes, MAXP);
        tick();
        out_ready = 1'b1;
        idle(2);

        // Randomized sequences with gaps and random output backpressure
        rand_mode = 1'b1;
        repeat (150) begin
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                beat(rand_x(), 1'($urandom_range(0, 1)), k == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
